// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith/shift ops plus iterative unsigned MUL/DIV.
// Latency 1 cycle (WIDTH for MUL/DIV); result held in DONE until out_ready, in_ready low meanwhile.
module alu_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   ALUIn1,
   input  logic [WIDTH-1:0]   ALUIn2,
   input  logic [3:0]         ALUSel,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   ALUOut,
   output logic [WIDTH-1:0]   ALUOutHi,
   output logic               zero,
   output logic               div_zero,
   output logic               op_err
);
   localparam int LW = $clog2(WIDTH);
   localparam int CW = LW + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_DIV  = 4'b0011;
   localparam logic [3:0] OP_MUL  = 4'b0100;
   localparam logic [3:0] OP_ASL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b0111;
   localparam logic [3:0] OP_SRL  = 4'b1000;
   localparam logic [3:0] OP_SLLV = 4'b1001;
   localparam logic [3:0] OP_SRLV = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             mul_op;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   // hi:lo doubles as product accumulator (MUL) or remainder:quotient (DIV)
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] it_hi;
   logic [WIDTH-1:0] it_lo;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (mul_op) begin
         it_hi = mul_sum[WIDTH:1];
         it_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         it_hi = div_diff[WIDTH-1:0];
         it_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
         it_hi = div_shift[WIDTH-1:0];
         it_lo = {lo[WIDTH-2:0], 1'b0};
      end
   end

   logic [LW-1:0]    sh;
   logic [LW-1:0]    vsh;
   logic             over;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_dz;
   logic             sc_err;
   logic             is_iter;

   always_comb begin
      sh      = shamt[LW-1:0];
      vsh     = ALUIn2[LW-1:0];
      over    = (shamt >> LW) != '0;
      sc_res  = '0;
      sc_hi   = '0;
      sc_dz   = 1'b0;
      sc_err  = 1'b0;
      is_iter = 1'b0;
      case (ALUSel)
         OP_AND:  sc_res = ALUIn1 & ALUIn2;
         OP_OR:   sc_res = ALUIn1 | ALUIn2;
         OP_ADD:  sc_res = ALUIn1 + ALUIn2;
         OP_SUB:  sc_res = ALUIn1 - ALUIn2;
         OP_DIV: begin
            if (ALUIn2 == '0) begin
               sc_res = '1;
               sc_hi  = ALUIn1;
               sc_dz  = 1'b1;
            end else begin
               is_iter = 1'b1;
            end
         end
         OP_MUL:  is_iter = 1'b1;
         OP_ASL, OP_SLL: sc_res = over ? '0 : (ALUIn1 << sh);
         OP_SRL:  sc_res = over ? '0 : (ALUIn1 >> sh);
         OP_SLLV: sc_res = ALUIn1 << vsh;
         OP_SRLV: sc_res = ALUIn1 >> vsh;
         OP_SRA:  sc_res = over ? {WIDTH{ALUIn1[WIDTH-1]}} : $unsigned($signed(ALUIn1) >>> sh);
         default: sc_err = 1'b1;
      endcase
   end

   assign in_ready = rst_n && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         mul_op    <= 1'b0;
         opb       <= '0;
         hi        <= '0;
         lo        <= '0;
         out_valid <= 1'b0;
         ALUOut    <= '0;
         ALUOutHi  <= '0;
         zero      <= 1'b0;
         div_zero  <= 1'b0;
         op_err    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  div_zero <= sc_dz;
                  op_err   <= sc_err;
                  if (is_iter) begin
                     mul_op <= (ALUSel == OP_MUL);
                     opb    <= (ALUSel == OP_MUL) ? ALUIn1 : ALUIn2;
                     lo     <= (ALUSel == OP_MUL) ? ALUIn2 : ALUIn1;
                     hi     <= '0;
                     cnt    <= CW'(WIDTH);
                     state  <= BUSY;
                  end else begin
                     ALUOut    <= sc_res;
                     ALUOutHi  <= sc_hi;
                     zero      <= (sc_res == '0);
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            BUSY: begin
               hi  <= it_hi;
               lo  <= it_lo;
               cnt <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  ALUOut    <= it_lo;
                  ALUOutHi  <= it_hi;
                  zero      <= (it_lo == '0);
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] ALUIn1;
   logic [31:0] ALUIn2;
   logic [3:0]  ALUSel;
   logic [5:0]  shamt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUOut;
   logic [31:0] ALUOutHi;
   logic        zero;
   logic        div_zero;
   logic        op_err;

   int n_assert = 0;
   int n_fail   = 0;
   int lat;
   logic busy_rdy;

   alu_seq #(.WIDTH(32), .SHAMT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ALUIn1(ALUIn1), .ALUIn2(ALUIn2), .ALUSel(ALUSel), .shamt(shamt),
      .out_valid(out_valid), .out_ready(out_ready), .ALUOut(ALUOut),
      .ALUOutHi(ALUOutHi), .zero(zero), .div_zero(div_zero), .op_err(op_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request in IDLE; returns 1ns after the acceptance edge with operands scrambled.
   task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] sa);
      int t;
      t = 0;
      while (!in_ready && t < 100) begin
         @(posedge clk); #1; t++;
      end
      chk("in_ready before issue", {63'b0, in_ready}, 64'd1);
      in_valid = 1'b1; ALUSel = sel; ALUIn1 = a; ALUIn2 = b; shamt = sa;
      @(posedge clk); #1;
      in_valid = 1'b0;
      ALUIn1 = $urandom; ALUIn2 = $urandom; ALUSel = 4'($urandom); shamt = 6'($urandom);
   endtask

   task automatic wait_done();
      lat = 0;
      busy_rdy = 1'b0;
      while (!out_valid && lat < 100) begin
         busy_rdy |= in_ready;
         @(posedge clk); #1; lat++;
      end
      chk("out_valid reached", {63'b0, out_valid}, 64'd1);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic run1(input string tag, input logic [3:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] sa, input logic [31:0] exp);
      issue(sel, a, b, sa);
      wait_done();
      chk({tag, " latency"}, 64'(lat), 64'd0);
      chk({tag, " ALUOut"}, {32'b0, ALUOut}, {32'b0, exp});
      chk({tag, " zero"}, {63'b0, zero}, {63'b0, (exp == 32'd0)});
      chk({tag, " ALUOutHi"}, {32'b0, ALUOutHi}, 64'd0);
      take();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      ALUIn1 = '0; ALUIn2 = '0; ALUSel = '0; shamt = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset out_valid", {63'b0, out_valid}, 64'd0);
      chk("reset in_ready", {63'b0, in_ready}, 64'd0);
      chk("reset ALUOut", {32'b0, ALUOut}, 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle in_ready", {63'b0, in_ready}, 64'd1);

      run1("ADD", 4'b0010, 32'd1, 32'd1, 6'd0, 32'd2);
      run1("SUB", 4'b0110, 32'd5, 32'd5, 6'd0, 32'd0);
      run1("ADD wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 6'd0, 32'd0);
      run1("OR", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 6'd0, 32'h0000_00FF);
      run1("SRA", 4'b1011, 32'h8000_0000, 32'd0, 6'd4, 32'hF800_0000);
      run1("SRA over", 4'b1011, 32'h8000_0000, 32'd0, 6'd33, 32'hFFFF_FFFF);
      run1("SRL", 4'b1000, 32'h8000_0000, 32'd0, 6'd31, 32'd1);
      run1("SLL over", 4'b0111, 32'd1, 32'd0, 6'd40, 32'd0);
      run1("ASL", 4'b0101, 32'd3, 32'd0, 6'd4, 32'd48);
      run1("SLLV", 4'b1001, 32'd1, 32'h21, 6'd0, 32'd2);
      run1("SRLV", 4'b1010, 32'h100, 32'h24, 6'd0, 32'h10);

      issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0);
      chk("MUL in_ready after accept", {63'b0, in_ready}, 64'd0);
      wait_done();
      chk("MUL latency", 64'(lat), 64'd32);
      chk("MUL in_ready while busy", {63'b0, busy_rdy}, 64'd0);
      chk("MUL lo", {32'b0, ALUOut}, 64'h0000_0001);
      chk("MUL hi", {32'b0, ALUOutHi}, 64'hFFFF_FFFE);
      take();

      issue(4'b0100, 32'h1234_5678, 32'h10, 6'd0);
      wait_done();
      chk("MUL2 product", {ALUOutHi, ALUOut}, 64'h0000_0001_2345_6780);
      take();

      issue(4'b0011, 32'd100, 32'd7, 6'd0);
      wait_done();
      chk("DIV latency", 64'(lat), 64'd32);
      chk("DIV quotient", {32'b0, ALUOut}, 64'd14);
      chk("DIV remainder", {32'b0, ALUOutHi}, 64'd2);
      chk("DIV div_zero", {63'b0, div_zero}, 64'd0);
      take();

      issue(4'b0011, 32'd7, 32'd100, 6'd0);
      wait_done();
      chk("DIV small quotient", {32'b0, ALUOut}, 64'd0);
      chk("DIV small zero", {63'b0, zero}, 64'd1);
      chk("DIV small remainder", {32'b0, ALUOutHi}, 64'd7);
      take();

      issue(4'b0011, 32'h1234, 32'd0, 6'd0);
      wait_done();
      chk("DIV0 latency", 64'(lat), 64'd0);
      chk("DIV0 ALUOut", {32'b0, ALUOut}, 64'hFFFF_FFFF);
      chk("DIV0 ALUOutHi", {32'b0, ALUOutHi}, 64'h1234);
      chk("DIV0 div_zero", {63'b0, div_zero}, 64'd1);
      take();

      // Backpressure: result must be held while out_ready stays low
      issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 6'd0);
      wait_done();
      chk("AND div_zero cleared", {63'b0, div_zero}, 64'd0);
      busy_rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         busy_rdy |= in_ready | ~out_valid | (ALUOut != 32'h0000_F000);
         @(posedge clk); #1;
      end
      chk("hold stable", {63'b0, busy_rdy}, 64'd0);
      chk("hold ALUOut", {32'b0, ALUOut}, 64'h0000_F000);
      take();
      chk("release in_ready", {63'b0, in_ready}, 64'd1);
      chk("release out_valid", {63'b0, out_valid}, 64'd0);

      // Reset in the middle of a MUL
      issue(4'b0100, 32'd3, 32'd5, 6'd0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midreset out_valid", {63'b0, out_valid}, 64'd0);
      chk("midreset in_ready", {63'b0, in_ready}, 64'd0);
      chk("midreset outputs", {ALUOutHi, ALUOut}, 64'd0);
      chk("midreset flags", {61'b0, zero, div_zero, op_err}, 64'd0);
      rst_n = 1'b1;
      busy_rdy = 1'b0;
      for (int i = 0; i < 40; i++) begin
         busy_rdy |= out_valid;
         @(posedge clk); #1;
      end
      chk("aborted op silent", {63'b0, busy_rdy}, 64'd0);
      run1("OR after reset", 4'b0001, 32'h0F, 32'hF0, 6'd0, 32'hFF);

      issue(4'b1111, 32'hDEAD_BEEF, 32'h1, 6'd0);
      wait_done();
      chk("ILL latency", 64'(lat), 64'd0);
      chk("ILL op_err", {63'b0, op_err}, 64'd1);
      chk("ILL ALUOut", {32'b0, ALUOut}, 64'd0);
      chk("ILL zero", {63'b0, zero}, 64'd1);
      take();
      issue(4'b0010, 32'd2, 32'd3, 6'd0);
      wait_done();
      chk("op_err cleared", {63'b0, op_err}, 64'd0);
      chk("ADD after ILL", {32'b0, ALUOut}, 64'd5);
      take();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
